dice_rf_port_bank: RTL and testbench
====================================

Name: dice_rf_port_bank

Overview:
- One port slice of the DICE CGRA general-purpose register file: a DEPTH x DATA_WIDTH storage bank with read/write address converters (bit-mask override) and a special-register source (thread/CTA IDs, constant).
- Read path returns either bank data or the special-register value with a fixed 1-cycle latency.
- The GPRF controller instantiates 16 of these, with latency pipes placed outside this block.

Parameters:
DATA_WIDTH, 32, data word width
NUM_TID, 512, bank depth (one entry per thread id)
MAX_CTA_ID, 65535, largest CTA id; CTAW = $clog2(MAX_CTA_ID+1)
RF_ADDR_WIDTH, $clog2(NUM_TID), address/tid width (AW)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of output/pipeline registers
rd_en  in  1  bank read enable
rd_tid  in  AW  read thread id
rd_ovr_en  in  AW  per-bit read address override mask
rd_ovr_addr  in  AW  read override bits
wr_en  in  1  bank write enable
wr_tid  in  AW  write thread id
wr_ovr_en  in  AW  per-bit write address override mask
wr_ovr_addr  in  AW  write override bits
wr_data  in  DATA_WIDTH  write data
spec_rd_en  in  1  select special register instead of bank
spec_sel  in  4  special register select
const_data  in  DATA_WIDTH  constant register value
tid_x/tid_y/tid_z, ntid_x/ntid_y/ntid_z  in  AW each  thread ids/dims
ctaid_x/ctaid_y/ctaid_z, nctaid_x/nctaid_y/nctaid_z  in  CTAW each  CTA ids/dims
rd_data  out  DATA_WIDTH  read result

Behaviour:
- Clocking and reset: single clock clk; reset is asynchronous, active-low (rst_n).
- Address conversion (combinational, both paths): addr = (tid & ~ovr_en) | (ovr_addr & ovr_en), bitwise. Result is used modulo NUM_TID. If NUM_TID is not a power of two, addr >= NUM_TID is ignored: writes are dropped, reads return 0.
- Write: on posedge, if wr_en and not in reset, mem[wr_addr] <= wr_data. Memory is not reset or cleared; contents are undefined until written.
- Bank read: 1-cycle latency.
  - posedge with rd_en=1: bank_q <= mem[rd_addr].
  - rd_en=0: bank_q holds.
  - Read and write to the same address in the same cycle return the OLD data (read-first).
- Special read: 1-cycle latency.
  - posedge with spec_rd_en=1: spec_q <= sel_value.
  - spec_rd_en=0: spec_q holds.
- spec_sel encoding, all values zero-extended to DATA_WIDTH:
  - 0 tid_x, 1 tid_y, 2 tid_z
  - 3 ntid_x, 4 ntid_y, 5 ntid_z
  - 6 ctaid_x, 7 ctaid_y, 8 ctaid_z
  - 9 nctaid_x, 10 nctaid_y, 11 nctaid_z
  - 12 const_data
  - 13-15 return 0
- Output mux: sel_q <= spec_rd_en each posedge; rd_data = sel_q ? spec_q : bank_q. rd_data always reflects the source requested in the previous cycle.
- Simultaneous rd_en and spec_rd_en: both registers update; rd_data shows spec_q.
- Reset (rst_n=0, async): bank_q, spec_q and sel_q go to 0, so rd_data=0. Writes during reset are ignored.
- clr=1 at posedge: bank_q, spec_q and sel_q go to 0 and clr overrides the same-cycle rd_en/spec_rd_en; the memory array is untouched and a same-cycle write still occurs.
- Reset asserted mid-operation: outputs return to 0 immediately; stored data is retained.
- No handshake; always ready; no internal state machine.

Test Plan:
- Write 0xDEADBEEF to tid 5 (no override), next cycle read tid 5 with rd_en=1 -> rd_data=0xDEADBEEF one cycle after the read edge; with rd_en=0 the next cycle, rd_data holds 0xDEADBEEF.
- Override: wr_tid=0x003, wr_ovr_en=0x1F0, wr_ovr_addr=0x0A0 -> data lands at address 0x0A3; read with rd_tid=0x0A3 and no override returns it; read of address 0x003 does not.
- Special registers: tid_y=7, ctaid_z=300, const_data=0x12345678; spec_sel=1 -> rd_data=7; spec_sel=8 -> 300; spec_sel=12 -> 0x12345678; spec_sel=14 -> 0; each result appears 1 cycle after the request.
- Mux alignment: cycle N rd_en (tid 5), cycle N+1 spec_rd_en (sel 12), cycle N+2 rd_en -> rd_data sequence is mem[5], 0x12345678, mem[5].
- Read-during-write at tid 9 (old 0x1, new 0x2) -> rd_data=0x1 next cycle; a following read returns 0x2.
- clr pulse and async rst_n pulse mid-run -> rd_data=0 (clr on the next edge, rst_n immediately); a subsequent read of tid 5 still returns 0xDEADBEEF.

Source files
------------

// File: rtl/dice_rf_port_bank_if.sv
// Bus bundle for one GPRF port slice: read/write/special-register controls and the read result.
interface dice_rf_port_bank_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_TID       = 512,
  parameter int MAX_CTA_ID    = 65535,
  parameter int RF_ADDR_WIDTH = $clog2(NUM_TID),
  parameter int CTAW          = $clog2(MAX_CTA_ID + 1)
);
  logic                     clr;
  logic                     rd_en;
  logic [RF_ADDR_WIDTH-1:0] rd_tid;
  logic [RF_ADDR_WIDTH-1:0] rd_ovr_en;
  logic [RF_ADDR_WIDTH-1:0] rd_ovr_addr;
  logic                     wr_en;
  logic [RF_ADDR_WIDTH-1:0] wr_tid;
  logic [RF_ADDR_WIDTH-1:0] wr_ovr_en;
  logic [RF_ADDR_WIDTH-1:0] wr_ovr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     spec_rd_en;
  logic [3:0]               spec_sel;
  logic [DATA_WIDTH-1:0]    const_data;
  logic [RF_ADDR_WIDTH-1:0] tid_x, tid_y, tid_z;
  logic [RF_ADDR_WIDTH-1:0] ntid_x, ntid_y, ntid_z;
  logic [CTAW-1:0]          ctaid_x, ctaid_y, ctaid_z;
  logic [CTAW-1:0]          nctaid_x, nctaid_y, nctaid_z;
  logic [DATA_WIDTH-1:0]    rd_data;

  modport master (
    output clr, rd_en, rd_tid, rd_ovr_en, rd_ovr_addr,
    output wr_en, wr_tid, wr_ovr_en, wr_ovr_addr, wr_data,
    output spec_rd_en, spec_sel, const_data,
    output tid_x, tid_y, tid_z, ntid_x, ntid_y, ntid_z,
    output ctaid_x, ctaid_y, ctaid_z, nctaid_x, nctaid_y, nctaid_z,
    input  rd_data
  );

  modport slave (
    input  clr, rd_en, rd_tid, rd_ovr_en, rd_ovr_addr,
    input  wr_en, wr_tid, wr_ovr_en, wr_ovr_addr, wr_data,
    input  spec_rd_en, spec_sel, const_data,
    input  tid_x, tid_y, tid_z, ntid_x, ntid_y, ntid_z,
    input  ctaid_x, ctaid_y, ctaid_z, nctaid_x, nctaid_y, nctaid_z,
    output rd_data
  );
endinterface

// File: rtl/dice_rf_port_bank.sv
// One GPRF port slice: NUM_TID x DATA_WIDTH bank with override address conversion,
// special-register source and a 1-cycle registered read mux.
module dice_rf_port_bank #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_TID       = 512,
  parameter int MAX_CTA_ID    = 65535,
  parameter int RF_ADDR_WIDTH = $clog2(NUM_TID)
) (
  input logic               clk,
  input logic               rst_n,
  dice_rf_port_bank_if.slave bus
);
  localparam int AW   = RF_ADDR_WIDTH;
  localparam int CTAW = $clog2(MAX_CTA_ID + 1);

  logic [DATA_WIDTH-1:0] mem [NUM_TID];

  logic [AW-1:0]         rd_addr, wr_addr;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] sel_value;
  logic [DATA_WIDTH-1:0] bank_d, bank_q;
  logic [DATA_WIDTH-1:0] spec_d, spec_q;
  logic                  sel_d, sel_q;

  // Address conversion: override bits replace tid bits where the mask is set.
  always_comb begin
    rd_addr = (bus.rd_tid & ~bus.rd_ovr_en) | (bus.rd_ovr_addr & bus.rd_ovr_en);
    wr_addr = (bus.wr_tid & ~bus.wr_ovr_en) | (bus.wr_ovr_addr & bus.wr_ovr_en);
    rd_ok   = 32'(rd_addr) < 32'(NUM_TID);
    wr_ok   = 32'(wr_addr) < 32'(NUM_TID);
  end

  // Storage write; never reset, and writes are blocked while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && bus.wr_en && wr_ok) mem[wr_addr] <= bus.wr_data;
  end

  // Special-register source select, zero-extended to the data width.
  always_comb begin
    sel_value = '0;
    case (bus.spec_sel)
      4'd0:  sel_value = {{(DATA_WIDTH-AW){1'b0}}, bus.tid_x};
      4'd1:  sel_value = {{(DATA_WIDTH-AW){1'b0}}, bus.tid_y};
      4'd2:  sel_value = {{(DATA_WIDTH-AW){1'b0}}, bus.tid_z};
      4'd3:  sel_value = {{(DATA_WIDTH-AW){1'b0}}, bus.ntid_x};
      4'd4:  sel_value = {{(DATA_WIDTH-AW){1'b0}}, bus.ntid_y};
      4'd5:  sel_value = {{(DATA_WIDTH-AW){1'b0}}, bus.ntid_z};
      4'd6:  sel_value = {{(DATA_WIDTH-CTAW){1'b0}}, bus.ctaid_x};
      4'd7:  sel_value = {{(DATA_WIDTH-CTAW){1'b0}}, bus.ctaid_y};
      4'd8:  sel_value = {{(DATA_WIDTH-CTAW){1'b0}}, bus.ctaid_z};
      4'd9:  sel_value = {{(DATA_WIDTH-CTAW){1'b0}}, bus.nctaid_x};
      4'd10: sel_value = {{(DATA_WIDTH-CTAW){1'b0}}, bus.nctaid_y};
      4'd11: sel_value = {{(DATA_WIDTH-CTAW){1'b0}}, bus.nctaid_z};
      4'd12: sel_value = bus.const_data;
      default: sel_value = '0;
    endcase
  end

  // Next-state for the read registers; clr wins over same-cycle read requests.
  always_comb begin
    bank_d = bank_q;
    spec_d = spec_q;
    sel_d  = bus.spec_rd_en;
    if (bus.clr) begin
      bank_d = '0;
      spec_d = '0;
      sel_d  = 1'b0;
    end else begin
      if (bus.rd_en)      bank_d = rd_ok ? mem[rd_addr] : '0;
      if (bus.spec_rd_en) spec_d = sel_value;
    end
  end

  // Read registers; the array read above sees pre-write contents (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      spec_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      spec_q <= spec_d;
      sel_q  <= sel_d;
    end
  end

  // Output mux follows the source requested on the previous edge.
  always_comb begin
    bus.rd_data = sel_q ? spec_q : bank_q;
  end
endmodule

// File: tb/tb_dice_rf_port_bank.sv
// Self-checking bench for dice_rf_port_bank: directed scenarios plus randomized traffic
// against a behavioural model of the bank contents and the last-requested read source.
module tb_dice_rf_port_bank;
  localparam int DW = 32;
  localparam int NT = 512;
  localparam int MC = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dice_rf_port_bank_if #(.DATA_WIDTH(DW), .NUM_TID(NT), .MAX_CTA_ID(MC)) bus ();

  dice_rf_port_bank #(.DATA_WIDTH(DW), .NUM_TID(NT), .MAX_CTA_ID(MC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Model: array contents plus the value of whichever source was last requested.
  logic [DW-1:0] ref_mem [NT];
  logic [DW-1:0] last_bank = '0;
  logic [DW-1:0] last_spec = '0;
  bit            show_spec = 1'b0;

  function automatic logic [DW-1:0] model_rd();
    return show_spec ? last_spec : last_bank;
  endfunction

  function automatic int unsigned conv(int unsigned tid, int unsigned en, int unsigned a);
    return ((tid & ~en) | (a & en)) % NT;
  endfunction

  function automatic logic [DW-1:0] spec_value(int unsigned sel);
    int unsigned v [16];
    v[0]  = bus.tid_x;    v[1]  = bus.tid_y;    v[2]  = bus.tid_z;
    v[3]  = bus.ntid_x;   v[4]  = bus.ntid_y;   v[5]  = bus.ntid_z;
    v[6]  = bus.ctaid_x;  v[7]  = bus.ctaid_y;  v[8]  = bus.ctaid_z;
    v[9]  = bus.nctaid_x; v[10] = bus.nctaid_y; v[11] = bus.nctaid_z;
    v[12] = bus.const_data;
    v[13] = 0; v[14] = 0; v[15] = 0;
    return v[sel];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.clr = 1'b0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.spec_rd_en = 1'b0;
    bus.rd_ovr_en = '0; bus.rd_ovr_addr = '0; bus.wr_ovr_en = '0; bus.wr_ovr_addr = '0;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge, check rd_data.
  task automatic tick(input string tag);
    int unsigned ra, wa;
    logic [DW-1:0] nb, ns;
    bit nsel;
    ra = conv(bus.rd_tid, bus.rd_ovr_en, bus.rd_ovr_addr);
    wa = conv(bus.wr_tid, bus.wr_ovr_en, bus.wr_ovr_addr);
    nb = last_bank; ns = last_spec; nsel = bus.spec_rd_en;
    if (bus.clr) begin
      nb = '0; ns = '0; nsel = 1'b0;
    end else begin
      if (bus.rd_en) nb = ref_mem[ra];
      if (bus.spec_rd_en) ns = spec_value(bus.spec_sel);
    end
    if (bus.wr_en) ref_mem[wa] = bus.wr_data;
    @(posedge clk);
    #1;
    last_bank = nb; last_spec = ns; show_spec = nsel;
    chk(tag, bus.rd_data, model_rd());
  endtask

  task automatic wr(input int unsigned tid, input logic [DW-1:0] d);
    idle(); bus.wr_en = 1'b1; bus.wr_tid = tid[8:0]; bus.wr_data = d;
  endtask

  task automatic rd(input int unsigned tid);
    idle(); bus.rd_en = 1'b1; bus.rd_tid = tid[8:0];
  endtask

  task automatic sp(input int unsigned sel);
    idle(); bus.spec_rd_en = 1'b1; bus.spec_sel = sel[3:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.rd_tid = '0; bus.wr_tid = '0; bus.wr_data = '0; bus.spec_sel = '0; bus.const_data = '0;
    bus.tid_x = '0; bus.tid_y = '0; bus.tid_z = '0; bus.ntid_x = '0; bus.ntid_y = '0; bus.ntid_z = '0;
    bus.ctaid_x = '0; bus.ctaid_y = '0; bus.ctaid_z = '0;
    bus.nctaid_x = '0; bus.nctaid_y = '0; bus.nctaid_z = '0;

    // Reset state.
    #22;
    chk("reset_rd_data", bus.rd_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the whole bank so every later read has a defined model value.
    for (int i = 0; i < NT; i++) begin
      wr(i, $urandom);
      @(posedge clk); #1;
      ref_mem[i] = bus.wr_data;
    end
    idle();
    tick("after_fill");

    // Basic write then read, then hold.
    wr(5, 32'hDEADBEEF); tick("wr5");
    rd(5);               tick("rd5");
    chk("rd5_const", bus.rd_data, 32'hDEADBEEF);
    idle();              tick("rd5_hold");
    chk("rd5_hold_const", bus.rd_data, 32'hDEADBEEF);

    // Write address override lands at 0x0A3.
    wr(3, 32'h0A3A0A3A);
    bus.wr_ovr_en = 9'h1F0; bus.wr_ovr_addr = 9'h0A0;
    tick("wr_ovr");
    rd(9'h0A3); tick("rd_0a3");
    chk("rd_0a3_const", bus.rd_data, 32'h0A3A0A3A);
    rd(9'h003); tick("rd_003");
    total++;
    assert (bus.rd_data !== 32'h0A3A0A3A) passed++;
    else $error("FAIL rd_003_not_ovr observed=%h expected=not %h", bus.rd_data, 32'h0A3A0A3A);
    // Read override path.
    rd(9'h013); bus.rd_ovr_en = 9'h0F0; bus.rd_ovr_addr = 9'h0A0; tick("rd_ovr");
    chk("rd_ovr_const", bus.rd_data, 32'h0A3A0A3A);

    // Special registers.
    bus.tid_y = 9'd7; bus.ctaid_z = 16'd300; bus.const_data = 32'h12345678;
    sp(1);  tick("sp_tid_y");  chk("sp_tid_y_const", bus.rd_data, 32'd7);
    sp(8);  tick("sp_ctaid_z"); chk("sp_ctaid_z_const", bus.rd_data, 32'd300);
    sp(12); tick("sp_const");  chk("sp_const_const", bus.rd_data, 32'h12345678);
    sp(14); tick("sp_14");     chk("sp_14_const", bus.rd_data, 32'd0);

    // Mux alignment.
    rd(5);  tick("mux_n");  chk("mux_n_const", bus.rd_data, 32'hDEADBEEF);
    sp(12); tick("mux_n1"); chk("mux_n1_const", bus.rd_data, 32'h12345678);
    rd(5);  tick("mux_n2"); chk("mux_n2_const", bus.rd_data, 32'hDEADBEEF);

    // Simultaneous bank and special read: special wins at the output.
    rd(5); bus.spec_rd_en = 1'b1; bus.spec_sel = 4'd1; tick("both");
    chk("both_const", bus.rd_data, 32'd7);

    // Read-during-write returns old data.
    wr(9, 32'h1); tick("rdw_pre");
    wr(9, 32'h2); bus.rd_en = 1'b1; bus.rd_tid = 9'd9; tick("rdw");
    chk("rdw_old", bus.rd_data, 32'h1);
    rd(9); tick("rdw_new"); chk("rdw_new_const", bus.rd_data, 32'h2);

    // clr overrides a same-cycle read but still lets the write through.
    rd(9); bus.clr = 1'b1; bus.spec_rd_en = 1'b1; bus.spec_sel = 4'd12;
    bus.wr_en = 1'b1; bus.wr_tid = 9'd20; bus.wr_data = 32'h55AA55AA;
    tick("clr"); chk("clr_const", bus.rd_data, 32'd0);
    rd(20); tick("clr_wr"); chk("clr_wr_const", bus.rd_data, 32'h55AA55AA);

    // Async reset mid-run: immediate zero, writes ignored, contents retained.
    rd(5); tick("pre_rst"); chk("pre_rst_const", bus.rd_data, 32'hDEADBEEF);
    wr(5, 32'h0BAD0BAD);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", bus.rd_data, 32'd0);
    last_bank = '0; last_spec = '0; show_spec = 1'b0;
    @(posedge clk); #1;
    chk("rst_hold", bus.rd_data, 32'd0);
    idle(); rst_n = 1'b1;
    tick("post_rst");
    rd(5); tick("post_rst_rd5"); chk("post_rst_rd5_const", bus.rd_data, 32'hDEADBEEF);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.clr        = ($urandom_range(0, 15) == 0);
      bus.rd_en      = $urandom_range(0, 1);
      bus.wr_en      = $urandom_range(0, 1);
      bus.spec_rd_en = ($urandom_range(0, 2) == 0);
      bus.rd_tid     = $urandom;  bus.wr_tid = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        bus.rd_ovr_en = $urandom; bus.rd_ovr_addr = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        bus.wr_ovr_en = $urandom; bus.wr_ovr_addr = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.rd_tid = bus.wr_tid; bus.rd_ovr_en = bus.wr_ovr_en; bus.rd_ovr_addr = bus.wr_ovr_addr;
      end
      bus.wr_data    = $urandom;
      bus.spec_sel   = $urandom;
      bus.const_data = $urandom;
      bus.tid_x = $urandom; bus.tid_y = $urandom; bus.tid_z = $urandom;
      bus.ntid_x = $urandom; bus.ntid_y = $urandom; bus.ntid_z = $urandom;
      bus.ctaid_x = $urandom; bus.ctaid_y = $urandom; bus.ctaid_z = $urandom;
      bus.nctaid_x = $urandom; bus.nctaid_y = $urandom; bus.nctaid_z = $urandom;
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
